mem_burst_master: RTL and testbench
===================================

Name: mem_burst_master

Overview:
- Initiator for the single-port synchronous-read RAM interface: `adr`, `dat_w`, `we` out; `dat_r` in.
- RAM read timing: the RAM registers `adr` at posedge and returns the word one cycle later.
- Accepts burst commands and moves data between the RAM and valid/ready streams:
  - read burst: RAM to `rd_*` stream.
  - write burst: `wr_*` stream to RAM.
- Sits between the RAM and any producer/consumer that must not handle RAM timing itself.

Parameters:
- AW, 4, RAM address width; RAM depth is 2^AW.
- DW, 8, RAM data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  1  0 = read burst, 1 = write burst.
- cmd_base  in  AW  first RAM address.
- cmd_len  in  AW  word count minus 1 (bursts of 1..2^AW words).
- wr_valid  in  1  write-data word offered.
- wr_ready  out  1  write word accepted on wr_valid & wr_ready.
- wr_data  in  DW  write-data word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts on rd_valid & rd_ready.
- rd_data  out  DW  read word.
- adr  out  AW  RAM address.
- dat_w  out  DW  RAM write data.
- we  out  1  RAM write enable.
- dat_r  in  DW  RAM read data; reflects the adr presented in the previous cycle.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; counters and FIFO cleared.
  - Next cycle: rd_valid=0, done=0, busy=0, cmd_ready=1, adr=0, dat_w=0.
  - we and wr_ready are gated by rst: both are 0 in any cycle with rst=0. No RAM write ever occurs during reset.
- States: IDLE, WRITE, READ, FINISH.
- IDLE:
  - cmd_ready=1.
  - On command handshake: latch base, len, op; clear index and issued/delivered counters.
  - Go to WRITE (op=1) or READ (op=0).
- Address rule: adr = (base + index) mod 2^AW. Bursts wrap; e.g. base=14, len=3 touches 14,15,0,1.
- WRITE:
  - wr_ready=1; we=wr_valid; dat_w=wr_data; adr=current write address. All combinational, zero latency.
  - Each accepted word increments index.
  - When the word with index==len is accepted, go to FINISH.
  - rd_valid=0 throughout.
- READ: address issue feeds a 2-entry result FIFO.
  - An address issues in cycle N when both hold:
    - issued count <= len;
    - FIFO occupancy + in-flight (0/1) < 2, where occupancy is computed after this cycle's pop.
  - On issue, adr=that address and index increments. When no issue, adr holds its last value.
  - The word for the address issued in cycle N is pushed from dat_r into the FIFO at the end of cycle N+1.
  - rd_valid = FIFO not empty; rd_data = FIFO head, registered (not dat_r combinationally).
  - Same-cycle push and pop are allowed. Steady state with rd_ready=1: one word per cycle.
  - First rd_valid appears 2 cycles after the command handshake.
  - Go to FINISH on the handshake of the (len+1)-th word.
  - we=0 and wr_ready=0 throughout.
  - Words are delivered strictly in address order; none dropped or duplicated under any rd_ready pattern.
- FINISH: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in FINISH.
- busy = (state != IDLE).
- cmd_valid outside IDLE is ignored. cmd_* may change freely once accepted.
- Reset mid-burst: aborts immediately.
  - FIFO flushed; no done pulse.
  - Partially written RAM words remain as written.

Test Plan:
- RAM model preloaded mem[i]=0xA0+i. Read burst base=2, len=3, rd_ready=1 -> rd_data 0xA2,0xA3,0xA4,0xA5 on consecutive cycles; first rd_valid 2 cycles after handshake; done pulses once.
- Write burst base=14, len=3, wr_data 0x11,0x22,0x33,0x44, wr_valid=1 -> mem[14]=0x11, mem[15]=0x22, mem[0]=0x33, mem[1]=0x44 (wrap). We asserted exactly 4 cycles. Follow-up read of base=14, len=3 returns 0x11,0x22,0x33,0x44.
- Read burst base=0, len=15 with rd_ready toggled 1,0,0,1,0,1,... -> exactly 16 words 0xA0..0xAF in order, no gaps or duplicates. rd_data held stable while rd_valid=1 and rd_ready=0.
- Write burst with wr_valid deasserted on alternate cycles -> we only in wr_valid cycles. Addresses advance only on accept. done follows the 4th accepted word.
- Reset mid-burst: assert rst=0 during the 3rd word of an 8-word write -> no we during or after reset; mem beyond word 2 untouched; cmd_ready=1 and busy=0 the cycle after reset is released; no done pulse.
- Command during burst: cmd_valid held high with a second command during a read -> ignored until IDLE. Second command accepted the cycle after done, and its data is correct.

Source files
------------

// File: rtl/mem_burst_master_if.sv
// Command, write-stream, read-stream and RAM port bundle for mem_burst_master.
// master = burst engine view; slave = the surrounding producer/consumer/RAM view.
interface mem_burst_master_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_base;
  logic [AW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic          we;
  logic [DW-1:0] dat_r;

  modport master (
    input  cmd_valid, cmd_op, cmd_base, cmd_len, wr_valid, wr_data, rd_ready, dat_r,
    output cmd_ready, wr_ready, rd_valid, rd_data, adr, dat_w, we
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_base, cmd_len, wr_valid, wr_data, rd_ready, dat_r,
    input  cmd_ready, wr_ready, rd_valid, rd_data, adr, dat_w, we
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst mover between a sync-read RAM and valid/ready streams. Writes pass through with zero latency;
// reads deliver the first word 2 cycles after the command, stall on rd_ready via a 2-entry FIFO.
module mem_burst_master #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_burst_master_if.master  bus,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] base_q, len_q, adr_q;
  logic [AW:0]   idx_q, dlv_q;
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    occ_q;
  logic          inflight_q;

  logic          cmd_hs, wr_acc, pop, issue;
  logic [1:0]    occ_pop;
  logic [AW-1:0] cur_adr;
  logic          cmd_ready, wr_ready, we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;

  assign cmd_hs  = (state == IDLE) && bus.cmd_valid;
  assign wr_acc  = (state == WRITE) && bus.wr_valid && rst;
  assign pop     = (state == READ) && (occ_q != 2'd0) && bus.rd_ready;
  assign occ_pop = occ_q - {1'b0, pop};
  // Issue only if the word can land in the FIFO, counting the one still in flight.
  assign issue   = (state == READ) && (idx_q <= {1'b0, len_q})
                   && ((occ_pop + {1'b0, inflight_q}) < 2'd2);
  assign cur_adr = base_q + idx_q[AW-1:0];

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    we        = 1'b0;
    dat_w     = '0;
    adr       = adr_q;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_nxt = bus.cmd_op ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = rst;
        we       = rst && bus.wr_valid;
        dat_w    = bus.wr_data;
        adr      = cur_adr;
        if (wr_acc && (idx_q == {1'b0, len_q})) state_nxt = FINISH;
      end
      READ: begin
        if (issue) adr = cur_adr;
        if (pop && (dlv_q == {1'b0, len_q})) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      adr_q      <= '0;
      idx_q      <= '0;
      dlv_q      <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      adr_q      <= adr;
      inflight_q <= issue;
      if (cmd_hs) begin
        base_q <= bus.cmd_base;
        len_q  <= bus.cmd_len;
        idx_q  <= '0;
        dlv_q  <= '0;
      end else if (wr_acc || issue) begin
        idx_q <= idx_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        dlv_q    <= dlv_q + 1'b1;
      end
      // dat_r now holds the word for the address issued last cycle.
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= bus.dat_r;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      occ_q <= occ_pop + {1'b0, inflight_q};
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.we        = we;
  assign bus.dat_w     = dat_w;
  assign bus.adr       = adr;
  assign bus.rd_valid  = (occ_q != 2'd0);
  assign bus.rd_data   = fifo_q[rd_ptr_q];
  assign busy          = (state != IDLE);
  assign done          = (state == FINISH);

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: behavioural sync-read RAM, golden memory image and a read scoreboard.
module tb_mem_burst_master;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, done;

  always #5 clk = ~clk;

  mem_burst_master_if #(.AW(AW), .DW(DW)) bus ();

  mem_burst_master #(.AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  logic [DW-1:0] ram     [16];
  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] sb [$];
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  int we_in_rst = 0;

  always @(posedge clk) begin
    if (bus.we) ram[bus.adr] <= bus.dat_w;
    bus.dat_r <= ram[bus.adr];
    if (rst && done) done_cnt <= done_cnt + 1;
    if (bus.we) we_cnt <= we_cnt + 1;
    if (!rst && bus.we) we_in_rst <= we_in_rst + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic op, input logic [AW-1:0] base, input logic [AW-1:0] len,
                           output int waited);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = base;
    bus.cmd_len   = len;
    waited = 0;
    #1;
    while (!bus.cmd_ready && waited < 200) begin
      step();
      #1;
      waited++;
    end
    check("cmd_accept", bus.cmd_ready, 1);
    step();
  endtask

  task automatic idle_chk(input string tag);
    #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
  endtask

  // pat: 0 = always ready, 1 = 1,0,0,1,0,1 repeating, 2 = random
  task automatic run_read(input logic [AW-1:0] base, input logic [AW-1:0] len, input int pat,
                          input logic hold, input logic [AW-1:0] nbase, input logic [AW-1:0] nlen);
    logic [5:0]    pat6 = 6'b101001;
    logic [AW-1:0] a;
    int s = 0, first = -1, last = -1, d0 = done_cnt;
    logic seen = 1'b0;
    if (hold) begin
      bus.cmd_op   = 1'b0;
      bus.cmd_base = nbase;
      bus.cmd_len  = nlen;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    for (int i = 0; i <= int'(len); i++) begin
      a = base + i[AW-1:0];
      sb.push_back(exp_mem[a]);
    end
    while (!seen && s < 300) begin
      bus.rd_ready = (pat == 0) ? 1'b1 : (pat == 1) ? pat6[s % 6] : 1'($urandom_range(0, 1));
      #1;
      if (bus.rd_valid && first < 0) begin
        first = s;
        check("rd_first_latency", s, 2);
      end
      if (bus.rd_valid) begin
        if (sb.size() == 0) check("rd_extra_word", 1, 0);
        else begin
          check("rd_data", bus.rd_data, sb[0]);
          if (bus.rd_ready) begin
            void'(sb.pop_front());
            last = s;
          end
        end
      end
      check("rd_we_low", bus.we, 0);
      check("rd_wr_ready_low", bus.wr_ready, 0);
      if (done) begin
        seen = 1'b1;
        check("finish_cmd_ready_low", bus.cmd_ready, 0);
        check("rd_words_left", sb.size(), 0);
      end
      s++;
      step();
    end
    check("rd_done_seen", seen, 1);
    check("rd_done_once", done_cnt - d0, 1);
    if (pat == 0) check("rd_back_to_back", last - first, len);
    sb.delete();
  endtask

  // pat: 0 = wr_valid always, 1 = wr_valid on alternate cycles; rst_at >= 0 resets at that word
  task automatic run_write(input logic [AW-1:0] base, input logic [AW-1:0] len, input int pat,
                           input int rst_at, input logic [DW-1:0] seed);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int i = 0, s = 0, d0 = done_cnt, w0 = we_cnt;
    logic seen = 1'b0;
    bus.cmd_valid = 1'b0;
    while (!seen && s < 300) begin
      a = base + i[AW-1:0];
      d = seed + 8'(8'h11 * i);
      if (i == rst_at) begin
        rst = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        #1;
        check("rst_we_low", bus.we, 0);
        check("rst_wr_ready_low", bus.wr_ready, 0);
        step();
        bus.wr_valid = 1'b0;
        #1;
        check("rst_we_low_2", bus.we, 0);
        step();
        rst = 1'b1;
        step();
        #1;
        check("post_rst_cmd_ready", bus.cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_we", we_in_rst, 0);
        return;
      end
      bus.wr_valid = (i <= int'(len)) && (pat == 0 || (s % 2) == 0);
      bus.wr_data  = d;
      #1;
      check("wr_we", bus.we, bus.wr_valid);
      check("wr_rd_valid_low", bus.rd_valid, 0);
      if (i <= int'(len)) begin
        check("wr_ready", bus.wr_ready, 1);
        check("wr_adr", bus.adr, a);
        if (bus.wr_valid) check("wr_dat_w", bus.dat_w, d);
      end
      if (bus.wr_valid && bus.wr_ready) begin
        exp_mem[a] = d;
        i++;
      end
      if (done) begin
        seen = 1'b1;
        check("wr_all_accepted", i, int'(len) + 1);
      end
      s++;
      step();
    end
    bus.wr_valid = 1'b0;
    check("wr_done_seen", seen, 1);
    check("wr_done_once", done_cnt - d0, 1);
    check("wr_we_cycles", we_cnt - w0, int'(len) + 1);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 16; i++) begin
      ram[i]     = 8'hA0 + 8'(i);
      exp_mem[i] = 8'hA0 + 8'(i);
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_base  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    step();
    step();
    #1;
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_adr", bus.adr, 0);
    check("reset_dat_w", bus.dat_w, 0);
    check("reset_we", bus.we, 0);
    check("reset_wr_ready", bus.wr_ready, 0);
    rst = 1'b1;
    step();

    issue_cmd(1'b0, 4'd2, 4'd3, w);
    run_read(4'd2, 4'd3, 0, 1'b0, 4'd0, 4'd0);
    idle_chk("rd1");

    issue_cmd(1'b1, 4'd14, 4'd3, w);
    run_write(4'd14, 4'd3, 0, -1, 8'h11);
    idle_chk("wr1");
    issue_cmd(1'b0, 4'd14, 4'd3, w);
    run_read(4'd14, 4'd3, 0, 1'b0, 4'd0, 4'd0);
    idle_chk("rd_wrap");

    issue_cmd(1'b0, 4'd0, 4'd15, w);
    run_read(4'd0, 4'd15, 1, 1'b0, 4'd0, 4'd0);
    idle_chk("rd_toggle");

    issue_cmd(1'b1, 4'd6, 4'd3, w);
    run_write(4'd6, 4'd3, 1, -1, 8'h60);
    idle_chk("wr_alt");

    issue_cmd(1'b0, 4'd4, 4'd3, w);
    run_read(4'd4, 4'd3, 2, 1'b1, 4'd9, 4'd2);
    issue_cmd(1'b0, 4'd9, 4'd2, w);
    check("chain_accept_wait", w, 0);
    run_read(4'd9, 4'd2, 0, 1'b0, 4'd0, 4'd0);
    idle_chk("chain");

    issue_cmd(1'b1, 4'd8, 4'd7, w);
    run_write(4'd8, 4'd7, 0, 2, 8'h80);
    issue_cmd(1'b0, 4'd8, 4'd7, w);
    run_read(4'd8, 4'd7, 0, 1'b0, 4'd0, 4'd0);
    idle_chk("post_rst_read");

    for (int i = 0; i < 16; i++) check($sformatf("mem_%0d", i), ram[i], exp_mem[i]);
    check("no_we_during_rst", we_in_rst, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
